// File: rtl/wgt_stream_server_pkg.sv
// Shared types and constants for the weight stream server and its bank.
package wgt_stream_server_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2
  } wgt_state_t;

  localparam int unsigned FC_LANES = 8;
  localparam int unsigned FC_BUS_W = 64;

  function automatic int unsigned DEPTH_OF(input int unsigned co, input int unsigned ci,
                                           input int unsigned k);
    return co * ci * k * k;
  endfunction

endpackage

// File: rtl/wgt_bank.sv
// Single-write, single-read register bank with a registered read port.
module wgt_bank #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ROWS  = 242,
  parameter int unsigned ROW_W = 8
) (
  input  logic             clk1,
  input  logic             i_wr_en,
  input  logic [ROW_W-1:0] i_wr_row,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [ROW_W-1:0] i_rd_row,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [ROWS];
  logic [WIDTH-1:0] r_rd;

  // Contents are deliberately not reset; the top masks reads until a beat is valid.
  always_ff @(posedge clk1) begin
    if (i_wr_en) r_mem[i_wr_row] <= i_wr_data;
    if (i_rd_en) r_rd <= r_mem[i_rd_row];
  end

  assign o_rd_data = r_rd;

endmodule

// File: rtl/wgt_stream_server.sv
// Weight-read responder: host-loaded storage streamed LANES weights per request, 1-cycle latency.
module wgt_stream_server
  import wgt_stream_server_pkg::*;
#(
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned LANES        = 1,
  parameter int unsigned DEPTH        = DEPTH_OF(2, 1, 11),
  parameter int unsigned ADDR_WIDTH   = 18
) (
  input  logic                          clk1,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [WEIGHT_WIDTH-1:0]       wr_data,
  input  logic                          load_done,
  input  logic                          start,
  input  logic                          rd_req,
  output logic [LANES*WEIGHT_WIDTH-1:0] rd_data,
  output logic                          rd_valid,
  output logic                          wrap,
  output logic                          ready,
  output logic                          err
);

  localparam int unsigned ROWS  = (DEPTH + LANES - 1) / LANES;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned PW    = ADDR_WIDTH + 1;

  wgt_state_t r_state, w_state_nxt;

  logic [ADDR_WIDTH-1:0]         r_ptr, w_ptr_nxt, w_base, w_wr_lane;
  logic [PW-1:0]                 w_base_end;
  logic [ROW_W-1:0]              w_wr_row, w_rd_row;
  logic [LANES-1:0]              r_lane_ok, w_lane_ok;
  logic [LANES*WEIGHT_WIDTH-1:0] w_bank_q;
  logic                          r_valid, r_wrap, r_err, w_err_nxt;
  logic                          w_serve, w_last, w_wr_ok;

  // start rewinds before the same-cycle request is served.
  assign w_base     = start ? '0 : r_ptr;
  assign w_base_end = {1'b0, w_base} + PW'(LANES);
  assign w_last     = w_base_end >= PW'(DEPTH);
  assign w_serve    = rd_req && (r_state == READY);
  assign w_wr_ok    = wr_en && (r_state != READY) && (wr_addr < ADDR_WIDTH'(DEPTH));
  assign w_wr_row   = ROW_W'(wr_addr / ADDR_WIDTH'(LANES));
  assign w_wr_lane  = wr_addr % ADDR_WIDTH'(LANES);
  assign w_rd_row   = ROW_W'(w_base / ADDR_WIDTH'(LANES));

  for (genvar b = 0; b < LANES; b++) begin : g_bank
    wgt_bank #(
      .WIDTH(WEIGHT_WIDTH),
      .ROWS (ROWS),
      .ROW_W(ROW_W)
    ) u_bank (
      .clk1     (clk1),
      .i_wr_en  (w_wr_ok && (w_wr_lane == ADDR_WIDTH'(b))),
      .i_wr_row (w_wr_row),
      .i_wr_data(wr_data),
      .i_rd_en  (w_serve),
      .i_rd_row (w_rd_row),
      .o_rd_data(w_bank_q[b*WEIGHT_WIDTH +: WEIGHT_WIDTH])
    );
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (load_done) w_state_nxt = READY;
               else if (wr_en) w_state_nxt = LOADING;
      LOADING: if (load_done) w_state_nxt = READY;
      READY:   w_state_nxt = READY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_serve)    w_ptr_nxt = w_last ? '0 : w_base_end[ADDR_WIDTH-1:0];
    else if (start) w_ptr_nxt = '0;
    w_err_nxt = r_err
              | (wr_en && ((r_state == READY) || (wr_addr >= ADDR_WIDTH'(DEPTH))))
              | (rd_req && (r_state != READY));
    for (int i = 0; i < LANES; i++) begin
      w_lane_ok[i] = ({1'b0, w_base} + PW'(i)) < PW'(DEPTH);
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      r_valid   <= 1'b0;
      r_wrap    <= 1'b0;
      r_err     <= 1'b0;
      r_lane_ok <= '0;
    end else begin
      r_ptr     <= w_ptr_nxt;
      r_valid   <= w_serve;
      r_wrap    <= w_serve && w_last;
      r_err     <= w_err_nxt;
      r_lane_ok <= w_lane_ok;
    end
  end

  // Bus must be zero when idle: the consumer ORs/accumulates on it.
  always_comb begin
    ready    = (r_state == READY);
    rd_valid = r_valid;
    wrap     = r_wrap;
    err      = r_err;
    rd_data  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (r_valid && r_lane_ok[i]) begin
        rd_data[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] = w_bank_q[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
    end
  end

endmodule

// File: doc/wgt_stream_server.md
Name: wgt_stream_server

Overview:
- Synthesizable responder for the accelerator's weight-read protocol: TOP raises a `wgt_read`-style request, and this block returns the next weight word(s) one cycle later.
- Replaces the behavioural weight feeders so conv layers (LANES=1) and FC layers (LANES=8, packed 64-bit) can be served from on-chip storage.
- Storage is loaded by a host write port, then streamed sequentially with wrap-around per layer pass.

Parameters:
- WEIGHT_WIDTH, 8, bits per weight.
- LANES, 1, weights returned per request (1 for conv, 8 for FC).
- DEPTH, 242, total weights stored (CO*CI*K*K or IN*OUT).
- ADDR_WIDTH, 18, width of write address and read pointer; must satisfy 2^ADDR_WIDTH > DEPTH.

Ports:
- clk1  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  host write strobe.
- wr_addr  in  ADDR_WIDTH  host write address, 0..DEPTH-1.
- wr_data  in  WEIGHT_WIDTH  host write data.
- load_done  in  1  pulse; storage is complete.
- start  in  1  pulse; rewinds the read pointer to 0 (driven by start_conv / end_pool / end_conv_x).
- rd_req  in  1  weight read request (the TOP's wgt_read / wgt_read_fc_x).
- rd_data  out  LANES*WEIGHT_WIDTH  weights; lane i occupies bits [i*W +: W], lane 0 = lowest address.
- rd_valid  out  1  rd_data is valid this cycle.
- wrap  out  1  pulse with the final beat of a pass.
- ready  out  1  state is READY.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (asynchronous, rst_n=0): rd_data=0, rd_valid=0, wrap=0, ready=0, err=0, ptr=0, state=EMPTY. Memory contents are undefined after reset.

State machine:
- EMPTY -> LOADING on wr_en.
- LOADING -> READY on load_done.
- load_done in EMPTY -> READY; contents are undefined, and this is legal.
- READY is held until reset. There is no path back to LOADING.

Writes:
- Accepted in EMPTY and LOADING: mem[wr_addr] <= wr_data.
- wr_addr >= DEPTH is ignored and sets err.
- wr_en in READY is ignored and sets err.

Reads:
- Latency is exactly 1 cycle. rd_req sampled high in READY gives rd_valid=1 next cycle, with rd_data = mem[ptr .. ptr+LANES-1].
- Lanes with address >= DEPTH read as 0.
- On a served request, ptr <= ptr+LANES. If ptr+LANES >= DEPTH, ptr <= 0 and wrap=1 alongside that beat's rd_valid.
- Back-to-back requests give one beat per cycle with no bubbles.
- When rd_valid=0, rd_data=0. This is required because TOP ORs/accumulates on the bus.

rd_req outside READY:
- No beat is produced (rd_valid=0) and ptr is unchanged.
- err is set.

start:
- ptr <= 0. start never consumes a weight.
- start together with rd_req in the same cycle: the request is served from address 0, then ptr=LANES.

err:
- Sticky; cleared only by reset.

Mid-operation reset:
- Outputs and ptr return to their reset values immediately.
- Any in-flight beat is dropped.
- The host must reload memory before READY can be used again.

Decomposition:
- Shared package holds `wgt_state_t` with EMPTY/LOADING/READY.
- Shared package holds a `DEPTH_OF(co,ci,k)` constant-function helper and the lane-packing width constant.
- One natural sub-module: wgt_bank, a single-write, single-read register bank.
  - LANES instances are used; bank b holds addresses with addr%LANES==b, depth ceil(DEPTH/LANES).
  - Each instance gives one registered read per cycle, so the parallel lane read needs no multi-port array.
- Top level holds the FSM, pointer, wrap/err logic, and output register.

Test Plan:
1. LANES=1, DEPTH=242, load mem[i]=i%256, load_done, then start + 242 consecutive rd_req -> beats 0..241 in order, each 1 cycle after its request. wrap=1 only on the beat of value 241. The next rd_req returns 0.
2. LANES=8, DEPTH=20, mem[i]=i+1, 3 requests -> rd_data 0x0807060504030201, 0x100F0E0D0C0B0A09, 0x0000000014131211. wrap on beat 3, ptr back to 0.
3. rd_req in EMPTY, then wr_en with wr_addr=DEPTH -> rd_valid stays 0, rd_data=0, err=1 and stays 1 after a later valid load.
4. After 5 beats, assert start and rd_req together -> returned beat is mem[0]. The following request returns mem[LANES].
5. Gapped requests (rd_req on alternate cycles) -> rd_valid alternates, rd_data=0 in the gap cycles, and the value sequence has no skips.
6. Drop rst_n mid-stream while rd_req is high -> rd_valid and ready fall immediately. After release: state EMPTY, and rd_req yields no beat and sets err.
